pig_hit_scheduler: RTL and testbench

- Per-frame collision scheduler for the pig objects.
- During the raster scan it records the first bird/pig pixel overlap for each live pig and latches that pixel's direction bits.
- At each vsync it resolves the recorded hits serially, one pig per cycle, into impulse forces, HP decrements and score.
- It holds each pig's force inputs stable for exactly one frame, so every pig consumes the impulse at exactly one vsync.

---
 rtl/pig_hit_scheduler.sv | 171 +++++++++++++++++
 tb/tb_pig_hit_scheduler.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pig_hit_scheduler.sv
// Per-frame collision scheduler for the pig objects.
// Scan phase records the first bird/pig overlap per live pig; at vsync the
// recorded hits are resolved one pig per cycle into impulse, HP and score.
module pig_hit_scheduler #(
    parameter int unsigned NUM_PIGS  = 3,
    parameter logic [16:0] FORCE_MAG = 17'd192,
    parameter logic [1:0]  PIG_HP    = 2'd2,
    parameter logic [2:0]  COOLDOWN  = 3'd4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    vsync,
    input  logic                    bird,
    input  logic [NUM_PIGS-1:0]     pig,
    input  logic [4*NUM_PIGS-1:0]   pig_dir,
    input  logic [16:0]             bird_vx,
    input  logic [16:0]             bird_vy,
    output logic [17*NUM_PIGS-1:0]  pig_force_x,
    output logic [17*NUM_PIGS-1:0]  pig_force_y,
    output logic [NUM_PIGS-1:0]     pig_alive,
    output logic [7:0]              score,
    output logic                    level_clear,
    output logic                    overrun
);

    localparam int unsigned IDX_W = (NUM_PIGS > 1) ? $clog2(NUM_PIGS) : 1;

    typedef enum logic {
        S_SCAN,
        S_RESOLVE
    } state_e;

    state_e                    state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [NUM_PIGS-1:0]       hit_acc_q, hit_acc_d;
    logic [4*NUM_PIGS-1:0]     dir_acc_q, dir_acc_d;
    logic [NUM_PIGS-1:0]       hit_lat_q, hit_lat_d;
    logic [4*NUM_PIGS-1:0]     dir_lat_q, dir_lat_d;
    logic [NUM_PIGS-1:0][1:0]  hp_q, hp_d;
    logic [NUM_PIGS-1:0][2:0]  cd_q, cd_d;
    logic [NUM_PIGS-1:0]       alive_q, alive_d;
    logic [7:0]                score_q, score_d;
    logic                      level_clear_q, level_clear_d;
    logic                      overrun_q, overrun_d;
    logic [17*NUM_PIGS-1:0]    fx_q, fx_d;
    logic [17*NUM_PIGS-1:0]    fy_q, fy_d;

    logic [16:0] half_vx, half_vy, neg_mag;

    // Arithmetic halving of the bird velocity and the negated lateral impulse
    always_comb begin
        half_vx = {bird_vx[16], bird_vx[16:1]};
        half_vy = {bird_vy[16], bird_vy[16:1]};
        neg_mag = (~FORCE_MAG) + 17'd1;
    end

    // Next-state logic: vsync latch/clear, scan accumulation, serial resolve
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        hit_acc_d     = hit_acc_q;
        dir_acc_d     = dir_acc_q;
        hit_lat_d     = hit_lat_q;
        dir_lat_d     = dir_lat_q;
        hp_d          = hp_q;
        cd_d          = cd_q;
        alive_d       = alive_q;
        score_d       = score_q;
        overrun_d     = overrun_q;
        fx_d          = fx_q;
        fy_d          = fy_q;
        level_clear_d = (alive_q == '0);

        if (vsync) begin
            // Forces drop to zero on the same edge the pigs sample them,
            // so each impulse is consumed at exactly one vsync.
            fx_d      = '0;
            fy_d      = '0;
            hit_lat_d = hit_acc_q;
            dir_lat_d = dir_acc_q;
            hit_acc_d = '0;
            dir_acc_d = '0;
            for (int unsigned i = 0; i < NUM_PIGS; i++) begin
                if (cd_q[i] != 3'd0) begin
                    cd_d[i] = cd_q[i] - 3'd1;
                end
            end
            if (state_q == S_RESOLVE) begin
                overrun_d = 1'b1;
            end
            state_d = S_RESOLVE;
            idx_d   = '0;
        end else begin
            for (int unsigned i = 0; i < NUM_PIGS; i++) begin
                if (bird && pig[i] && alive_q[i] && (cd_q[i] == 3'd0) && !hit_acc_q[i]) begin
                    hit_acc_d[i]         = 1'b1;
                    dir_acc_d[4*i +: 4]  = pig_dir[4*i +: 4];
                end
            end
            if (state_q == S_RESOLVE) begin
                for (int unsigned i = 0; i < NUM_PIGS; i++) begin
                    if ((idx_q == IDX_W'(i)) && hit_lat_q[i] && alive_q[i]) begin
                        fx_d[17*i +: 17] = dir_lat_q[4*i+3] ? half_vx
                                         : (dir_lat_q[4*i+1] ? neg_mag : FORCE_MAG);
                        fy_d[17*i +: 17] = dir_lat_q[4*i+2] ? half_vy
                                         : (dir_lat_q[4*i+0] ? neg_mag : FORCE_MAG);
                        hp_d[i] = hp_q[i] - 2'd1;
                        cd_d[i] = COOLDOWN;
                        if (hp_q[i] == 2'd1) begin
                            alive_d[i] = 1'b0;
                            if (score_q != 8'hFF) begin
                                score_d = score_q + 8'd1;
                            end
                        end
                    end
                end
                if (idx_q == IDX_W'(NUM_PIGS - 1)) begin
                    state_d = S_SCAN;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_SCAN;
            idx_q         <= '0;
            hit_acc_q     <= '0;
            dir_acc_q     <= '0;
            hit_lat_q     <= '0;
            dir_lat_q     <= '0;
            for (int unsigned i = 0; i < NUM_PIGS; i++) begin
                hp_q[i] <= PIG_HP;
                cd_q[i] <= 3'd0;
            end
            alive_q       <= '1;
            score_q       <= '0;
            level_clear_q <= 1'b0;
            overrun_q     <= 1'b0;
            fx_q          <= '0;
            fy_q          <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            hit_acc_q     <= hit_acc_d;
            dir_acc_q     <= dir_acc_d;
            hit_lat_q     <= hit_lat_d;
            dir_lat_q     <= dir_lat_d;
            hp_q          <= hp_d;
            cd_q          <= cd_d;
            alive_q       <= alive_d;
            score_q       <= score_d;
            level_clear_q <= level_clear_d;
            overrun_q     <= overrun_d;
            fx_q          <= fx_d;
            fy_q          <= fy_d;
        end
    end

    assign pig_force_x = fx_q;
    assign pig_force_y = fy_q;
    assign pig_alive   = alive_q;
    assign score       = score_q;
    assign level_clear = level_clear_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_pig_hit_scheduler.sv
// Self-checking bench for pig_hit_scheduler: directed scenarios plus random
// frames, checked against a frame-level reference model.
module tb_pig_hit_scheduler;

    localparam int N = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            vsync = 1'b0;
    logic            bird = 1'b0;
    logic [N-1:0]    pig = '0;
    logic [4*N-1:0]  pig_dir = '0;
    logic [16:0]     bird_vx = '0;
    logic [16:0]     bird_vy = '0;
    logic [17*N-1:0] pig_force_x, pig_force_y;
    logic [N-1:0]    pig_alive;
    logic [7:0]      score;
    logic            level_clear, overrun;

    pig_hit_scheduler #(.NUM_PIGS(N)) dut (
        .clk(clk), .rst(rst), .vsync(vsync), .bird(bird), .pig(pig),
        .pig_dir(pig_dir), .bird_vx(bird_vx), .bird_vy(bird_vy),
        .pig_force_x(pig_force_x), .pig_force_y(pig_force_y),
        .pig_alive(pig_alive), .score(score),
        .level_clear(level_clear), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state (frame level)
    int          m_hp [N];
    int          m_cd [N];
    bit          m_alive [N];
    bit          m_acc [N];
    logic [3:0]  m_dir [N];
    logic [16:0] m_fx [N];
    logic [16:0] m_fy [N];
    int          m_score;
    bit          m_overrun;
    int          since;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [16:0] impulse(input bit centre, input bit neg, input logic [16:0] v);
        int s;
        logic [31:0] t;
        if (centre) begin
            s = int'($signed(v));
            s = (s < 0 && (s % 2) != 0) ? (s / 2 - 1) : (s / 2);
        end else begin
            s = neg ? -192 : 192;
        end
        t = s;
        return t[16:0];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_hp[i] = 2; m_cd[i] = 0; m_alive[i] = 1; m_acc[i] = 0;
            m_dir[i] = '0; m_fx[i] = '0; m_fy[i] = '0;
        end
        m_score = 0; m_overrun = 0; since = N + 5;
    endtask

    function automatic bit all_dead();
        for (int i = 0; i < N; i++) if (m_alive[i]) return 0;
        return 1;
    endfunction

    // Apply the model to the inputs of this cycle, then advance one clock
    task automatic tick();
        if (rst) begin
            model_reset();
        end else if (vsync) begin
            if (since < N) m_overrun = 1;
            for (int i = 0; i < N; i++) begin
                m_fx[i] = '0; m_fy[i] = '0;
                if (m_cd[i] > 0) m_cd[i]--;
            end
            for (int i = 0; i < N; i++) begin
                if (m_acc[i]) begin
                    m_fx[i] = impulse(m_dir[i][3], m_dir[i][1], bird_vx);
                    m_fy[i] = impulse(m_dir[i][2], m_dir[i][0], bird_vy);
                    m_hp[i]--;
                    m_cd[i] = 4;
                    if (m_hp[i] == 0) begin
                        m_alive[i] = 0;
                        if (m_score < 255) m_score++;
                    end
                end
                m_acc[i] = 0;
            end
            since = 0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (bird && pig[i] && m_alive[i] && m_cd[i] == 0 && !m_acc[i]) begin
                    m_acc[i] = 1;
                    m_dir[i] = pig_dir[4*i +: 4];
                end
            end
            if (since < N + 5) since++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        logic [N-1:0] ea;
        for (int i = 0; i < N; i++) begin
            ea[i] = m_alive[i];
            chk($sformatf("%s fx%0d", tag, i), 32'(pig_force_x[17*i +: 17]), 32'(m_fx[i]));
            chk($sformatf("%s fy%0d", tag, i), 32'(pig_force_y[17*i +: 17]), 32'(m_fy[i]));
        end
        chk({tag, " alive"}, 32'(pig_alive), 32'(ea));
        chk({tag, " score"}, 32'(score), 32'(m_score));
        chk({tag, " level_clear"}, 32'(level_clear), 32'(all_dead()));
        chk({tag, " overrun"}, 32'(overrun), 32'(m_overrun));
    endtask

    task automatic idle();
        bird = 0; pig = '0; pig_dir = '0; vsync = 0;
    endtask

    task automatic quiet(input int n);
        idle();
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic pixel(input bit b, input logic [N-1:0] p, input logic [4*N-1:0] d);
        bird = b; pig = p; pig_dir = d;
        tick();
        idle();
    endtask

    // vsync cycle; an overlap is also presented to show it is discarded
    task automatic vs();
        vsync = 1; bird = 1; pig = '1; pig_dir = 12'hFFF;
        tick();
        idle();
    endtask

    task automatic frame_end(input string tag);
        quiet(2);
        vs();
        quiet(N + 2);
        check_all(tag);
    endtask

    task automatic do_reset();
        rst = 1; idle();
        tick(); tick();
        rst = 0;
    endtask

    initial begin
        model_reset();

        // 1: reset and empty frames
        do_reset();
        chk("rst alive", 32'(pig_alive), 32'h7);
        chk("rst score", 32'(score), 32'h0);
        chk("rst force", 32'(pig_force_x[16:0]), 32'h0);
        check_all("rst");
        for (int f = 0; f < 3; f++) frame_end("empty");

        // 2: right-of-centre hit on pig 0
        quiet(2);
        pixel(1, 3'b001, 12'h002);
        frame_end("t2");
        chk("t2 fx0", 32'(pig_force_x[16:0]), 32'h1FF40);
        chk("t2 fy0", 32'(pig_force_y[16:0]), 32'd192);
        vs();
        chk("t2 fx0 cleared", 32'(pig_force_x[16:0]), 32'h0);
        chk("t2 fy0 cleared", 32'(pig_force_y[16:0]), 32'h0);
        quiet(N + 2);
        check_all("t2b");

        // 3: centred hit on pig 1 uses half velocity; later overlap ignored
        bird_vx = 17'h1FF00; bird_vy = 17'd130;
        pixel(1, 3'b010, 12'h0C0);
        pixel(1, 3'b010, 12'h030);
        frame_end("t3");
        chk("t3 fx1", 32'(pig_force_x[33:17]), 32'h1FF80);
        chk("t3 fy1", 32'(pig_force_y[33:17]), 32'd65);

        // 4: cooldown on pig 2, then kill, then dead pig ignores hits
        pixel(1, 3'b100, 12'h100);
        frame_end("t4 f0");
        for (int f = 1; f <= 4; f++) begin
            pixel(1, 3'b100, 12'h100);
            frame_end("t4 cd");
            chk("t4 cd fx2", 32'(pig_force_x[50:34]), 32'h0);
        end
        pixel(1, 3'b100, 12'h100);
        frame_end("t4 kill");
        chk("t4 alive", 32'(pig_alive), 32'h3);
        chk("t4 score", 32'(score), 32'd1);
        pixel(1, 3'b100, 12'h100);
        frame_end("t4 dead");
        chk("t4 dead fx2", 32'(pig_force_x[50:34]), 32'h0);

        // 5: kill remaining pigs, level_clear one cycle after last alive bit
        pixel(1, 3'b011, 12'h0A5);
        quiet(2);
        vs();
        for (int k = 0; k < 8 && pig_alive != '0; k++) tick();
        chk("t5 alive zero", 32'(pig_alive), 32'h0);
        chk("t5 lc early", 32'(level_clear), 32'h0);
        tick();
        chk("t5 lc", 32'(level_clear), 32'h1);
        chk("t5 score", 32'(score), 32'd3);
        quiet(N);
        check_all("t5");

        // 6: overrun on close vsyncs, then reset mid-RESOLVE
        do_reset();
        quiet(3);
        vs();
        tick();
        vs();
        chk("t6 overrun", 32'(overrun), 32'h1);
        quiet(N + 4);
        chk("t6 overrun sticky", 32'(overrun), 32'h1);
        check_all("t6");
        bird_vx = 17'd40;
        pixel(1, 3'b001, 12'h00A);
        vs();
        tick();
        rst = 1;
        tick();
        rst = 0;
        chk("t6 rst fx", 32'(pig_force_x), 32'h0);
        chk("t6 rst fy", 32'(pig_force_y), 32'h0);
        chk("t6 rst alive", 32'(pig_alive), 32'h7);
        chk("t6 rst score", 32'(score), 32'h0);
        chk("t6 rst lc", 32'(level_clear), 32'h0);
        chk("t6 rst overrun", 32'(overrun), 32'h0);
        check_all("t6 rst");

        // Random episodes
        for (int e = 0; e < 4; e++) begin
            do_reset();
            for (int f = 0; f < 40 && !all_dead(); f++) begin
                bird_vx = 17'($urandom);
                bird_vy = 17'($urandom);
                for (int c = 0; c < 24; c++) begin
                    bird = ($urandom_range(0, 5) == 0);
                    pig = N'($urandom);
                    pig_dir = 12'($urandom);
                    tick();
                end
                frame_end("rand");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
